// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map, widths and lane helpers shared by the GPIO block
package gpio_pkg;

    localparam int MAX_IO = 32;

    localparam logic [15:0] REG_DATA    = 16'h0000;
    localparam logic [15:0] REG_DIR     = 16'h0004;
    localparam logic [15:0] REG_SET     = 16'h0008;
    localparam logic [15:0] REG_CLR     = 16'h000C;
    localparam logic [15:0] REG_TGL     = 16'h0010;
    localparam logic [15:0] REG_RISE_EN = 16'h0014;
    localparam logic [15:0] REG_FALL_EN = 16'h0018;
    localparam logic [15:0] REG_STATUS  = 16'h001C;
    localparam logic [15:0] REG_OUT     = 16'h0020;

    function automatic logic [MAX_IO-1:0] lane_mask(input logic [3:0] wr);
        logic [MAX_IO-1:0] m;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{wr[k]}};
        end
        return m;
    endfunction

    // Bits at or above the implemented pin count never hold state.
    function automatic logic [MAX_IO-1:0] pin_mask(input int n);
        if (n >= MAX_IO) begin
            return '1;
        end
        return (MAX_IO'(1) << n) - MAX_IO'(1);
    endfunction

endpackage

// File: rtl/icosoc_mod_gpio_irq_if.sv
// rtl/icosoc_mod_gpio_irq_if.sv - icoSoC ctrl bus bundle with master/slave views
interface icosoc_mod_gpio_irq_if;
    logic [3:0]  ctrl_wr;
    logic        ctrl_rd;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;

    modport master (
        output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
        input  ctrl_rdat, ctrl_done
    );

    modport slave (
        input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
        output ctrl_rdat, ctrl_done
    );
endinterface

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - per-pin input synchroniser with one-cycle-delayed copy for edge detect
module gpio_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);
    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stage_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= din_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/sb_io.sv
// rtl/sb_io.sv - behavioural iCE40 SB_IO subset: unregistered tristate output, unregistered input
module SB_IO #(
    parameter logic [5:0] PIN_TYPE = 6'b1010_01,
    parameter logic       PULLUP   = 1'b0
) (
    inout  wire  PACKAGE_PIN,
    input  logic OUTPUT_ENABLE,
    input  logic D_OUT_0,
    output logic D_IN_0
);
    localparam logic TRISTATE_OUT = (PIN_TYPE[5:2] == 4'b1010);

    assign PACKAGE_PIN = (TRISTATE_OUT && OUTPUT_ENABLE) ? D_OUT_0 : 1'bz;
    assign D_IN_0      = PACKAGE_PIN;

    if (PULLUP) begin : g_pullup
        pullup (PACKAGE_PIN);
    end
endmodule

// File: rtl/icosoc_mod_gpio_irq.sv
// rtl/icosoc_mod_gpio_irq.sv - GPIO peripheral: register file, sticky edge status, irq and SB_IO pads
module icosoc_mod_gpio_irq
    import gpio_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 0,
    parameter int IO_LENGTH     = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    icosoc_mod_gpio_irq_if.slave  ctrl,
    output logic                  irq,
    inout  wire  [IO_LENGTH-1:0]  IO
);
    localparam logic [MAX_IO-1:0] VALID = pin_mask(IO_LENGTH);

    logic [MAX_IO-1:0] io_out_q, io_out_d;
    logic [MAX_IO-1:0] io_dir_q, io_dir_d;
    logic [MAX_IO-1:0] rise_en_q, rise_en_d;
    logic [MAX_IO-1:0] fall_en_q, fall_en_d;
    logic [MAX_IO-1:0] status_q, status_d;
    logic [31:0]       rdat_q, rdat_d;
    logic              done_q;
    logic              irq_q;

    logic [IO_LENGTH-1:0] pin_in, sync, rise, fall;
    logic [MAX_IO-1:0]    sync_w, edge_set, wmask, wbits, w1c, rd_val;
    logic                 acc;

    gpio_sync_edge #(
        .WIDTH       (IO_LENGTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .resetn (resetn),
        .din_i  (pin_in),
        .sync_o (sync),
        .rise_o (rise),
        .fall_o (fall)
    );

    for (genvar i = 0; i < IO_LENGTH; i++) begin : g_pad
        SB_IO #(
            .PIN_TYPE (6'b1010_01),
            .PULLUP   (1'b0)
        ) u_io (
            .PACKAGE_PIN   (IO[i]),
            .OUTPUT_ENABLE (io_dir_q[i]),
            .D_OUT_0       (io_out_q[i]),
            .D_IN_0        (pin_in[i])
        );
    end

    // Only one access per done pulse: a request still held while done is high is not re-accepted.
    assign acc = ((|ctrl.ctrl_wr) || ctrl.ctrl_rd) && !done_q;

    always_comb begin
        sync_w   = '0;
        edge_set = '0;
        sync_w[IO_LENGTH-1:0]   = sync;
        edge_set[IO_LENGTH-1:0] = (rise & rise_en_q[IO_LENGTH-1:0])
                                | (fall & fall_en_q[IO_LENGTH-1:0]);
        wmask = acc ? (lane_mask(ctrl.ctrl_wr) & VALID) : '0;
        wbits = ctrl.ctrl_wdat & wmask;
    end

    // Read mux sees pre-write state, so a combined read+write returns the old value.
    always_comb begin
        rd_val = '0;
        case (ctrl.ctrl_addr)
            REG_DATA:    rd_val = sync_w;
            REG_DIR:     rd_val = io_dir_q;
            REG_RISE_EN: rd_val = rise_en_q;
            REG_FALL_EN: rd_val = fall_en_q;
            REG_STATUS:  rd_val = status_q;
            REG_OUT:     rd_val = io_out_q;
            default:     rd_val = '0;
        endcase
        rdat_d = (acc && ctrl.ctrl_rd) ? rd_val : '0;
    end

    always_comb begin
        io_out_d  = io_out_q;
        io_dir_d  = io_dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        case (ctrl.ctrl_addr)
            REG_DATA:    io_out_d  = (io_out_q & ~wmask) | wbits;
            REG_SET:     io_out_d  = io_out_q | wbits;
            REG_CLR:     io_out_d  = io_out_q & ~wbits;
            REG_TGL:     io_out_d  = io_out_q ^ wbits;
            REG_DIR:     io_dir_d  = (io_dir_q & ~wmask) | wbits;
            REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | wbits;
            REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | wbits;
            REG_STATUS:  w1c       = wbits;
            default:     w1c       = '0;
        endcase
        // A fresh edge outranks a clear landing on the same cycle.
        status_d = (status_q & ~w1c) | edge_set;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            io_out_q  <= '0;
            io_dir_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            rdat_q    <= '0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            io_out_q  <= io_out_d;
            io_dir_q  <= io_dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            rdat_q    <= rdat_d;
            done_q    <= acc;
            irq_q     <= |status_q;
        end
    end

    assign ctrl.ctrl_rdat = rdat_q;
    assign ctrl.ctrl_done = done_q;
    assign irq            = irq_q;
endmodule

// File: tb/tb_icosoc_mod_gpio_irq.sv
// tb/tb_icosoc_mod_gpio_irq.sv - directed self-checking bench for the GPIO block (32-pin and 8-pin builds)
module tb_icosoc_mod_gpio_irq;
    import gpio_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic irq, irq8;
    wire  [31:0] io_pins;
    wire  [7:0]  io8_pins;
    logic [31:0] tb_en = '0;
    logic [31:0] tb_val = '0;
    logic [31:0] rd;
    logic        irq_at_done;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign io_pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    icosoc_mod_gpio_irq_if bus ();
    icosoc_mod_gpio_irq_if bus8 ();

    icosoc_mod_gpio_irq #(.CLOCK_FREQ_HZ(0), .IO_LENGTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .ctrl(bus.slave), .irq(irq), .IO(io_pins));

    icosoc_mod_gpio_irq #(.CLOCK_FREQ_HZ(0), .IO_LENGTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .resetn(resetn), .ctrl(bus8.slave), .irq(irq8), .IO(io8_pins));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input int sel, input logic [3:0] wr, input logic rdq,
                         input logic [15:0] addr, input logic [31:0] wdat);
        if (sel == 0) begin
            bus.ctrl_wr = wr; bus.ctrl_rd = rdq; bus.ctrl_addr = addr; bus.ctrl_wdat = wdat;
        end else begin
            bus8.ctrl_wr = wr; bus8.ctrl_rd = rdq; bus8.ctrl_addr = addr; bus8.ctrl_wdat = wdat;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following done.
    task automatic access(input int sel, input logic [3:0] wr, input logic rdq,
                          input logic [15:0] addr, input logic [31:0] wdat,
                          output logic [31:0] rdat);
        int   n;
        logic dn;
        n = 0;
        drive(sel, wr, rdq, addr, wdat);
        do begin
            @(posedge clk); #1;
            n++;
            dn = (sel == 0) ? bus.ctrl_done : bus8.ctrl_done;
        end while (!dn && n < 8);
        chk("done_latency", n, 1);
        rdat = (sel == 0) ? bus.ctrl_rdat : bus8.ctrl_rdat;
        irq_at_done = irq;
        drive(sel, 4'h0, 1'b0, 16'h0, 32'h0);
        @(posedge clk); #1;
        dn = (sel == 0) ? bus.ctrl_done : bus8.ctrl_done;
        chk("done_one_cycle", {31'b0, dn}, 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        drive(0, 4'h0, 1'b0, 16'h0, 32'h0);
        drive(1, 4'h0, 1'b0, 16'h0, 32'h0);
        cycles(3);
        resetn = 1'b1;
        cycles(1);

        // Reset state
        access(0, 4'h0, 1'b1, REG_DIR, 0, rd);    chk("reset_dir", rd, 32'h0);
        access(0, 4'h0, 1'b1, REG_OUT, 0, rd);    chk("reset_out", rd, 32'h0);
        access(0, 4'h0, 1'b1, REG_STATUS, 0, rd); chk("reset_status", rd, 32'h0);
        chk("reset_irq", {31'b0, irq}, 0);

        // Output path: DATA/SET/CLR/TGL
        access(0, 4'hF, 1'b0, REG_DIR,  32'hFFFF_FFFF, rd);
        access(0, 4'hF, 1'b0, REG_DATA, 32'h0000_00F0, rd);
        access(0, 4'hF, 1'b0, REG_SET,  32'h0000_0001, rd);
        access(0, 4'hF, 1'b0, REG_CLR,  32'h0000_0010, rd);
        access(0, 4'hF, 1'b0, REG_TGL,  32'h0000_0003, rd);
        access(0, 4'h0, 1'b1, REG_OUT, 0, rd);    chk("out_after_ops", rd, 32'h0000_00E2);
        chk("pins_driven", io_pins, 32'h0000_00E2);
        access(0, 4'h0, 1'b1, REG_DATA, 0, rd);   chk("data_reads_pins", rd, 32'h0000_00E2);
        access(0, 4'h0, 1'b1, REG_SET, 0, rd);    chk("set_reads_zero", rd, 32'h0);

        // Byte lanes and combined read+write
        access(0, 4'hF, 1'b0, REG_DIR, 32'h0, rd);
        access(0, 4'b0100, 1'b0, REG_DIR, 32'hAABB_CCDD, rd);
        access(0, 4'h0, 1'b1, REG_DIR, 0, rd);    chk("dir_byte_lane", rd, 32'h00BB_0000);
        access(0, 4'hF, 1'b1, REG_DIR, 32'h0, rd); chk("rw_returns_old", rd, 32'h00BB_0000);
        access(0, 4'h0, 1'b1, REG_DIR, 0, rd);    chk("rw_write_applied", rd, 32'h0);
        access(0, 4'h0, 1'b1, 16'h0040, 0, rd);   chk("unmapped_read", rd, 32'h0);

        // Rising edge flag and irq latency
        tb_en = 32'hFFFF_FFFF; tb_val = '0;
        cycles(4);
        access(0, 4'hF, 1'b0, REG_RISE_EN, 32'h1, rd);
        @(posedge clk); #1; tb_val[0] = 1'b1;
        cycles(2); chk("irq_t2", {31'b0, irq}, 0);
        cycles(1); chk("irq_t3", {31'b0, irq}, 0);
        cycles(1); chk("irq_t4", {31'b0, irq}, 1);
        access(0, 4'h0, 1'b1, REG_STATUS, 0, rd); chk("status_rise", rd, 32'h1);
        access(0, 4'hF, 1'b0, REG_STATUS, 32'h1, rd);
        chk("irq_at_w1c_done", {31'b0, irq_at_done}, 1);
        chk("irq_after_w1c", {31'b0, irq}, 0);
        tb_val[0] = 1'b0;
        cycles(6);
        access(0, 4'h0, 1'b1, REG_STATUS, 0, rd); chk("fall_disabled", rd, 32'h0);
        chk("irq_fall_disabled", {31'b0, irq}, 0);

        // Edge and clear on the same cycle: set wins
        access(0, 4'hF, 1'b0, REG_FALL_EN, 32'h1, rd);
        tb_val[0] = 1'b1;
        cycles(6);
        access(0, 4'h0, 1'b1, REG_STATUS, 0, rd); chk("status_rise2", rd, 32'h1);
        @(posedge clk); #1; tb_val[0] = 1'b0;
        cycles(2);
        access(0, 4'hF, 1'b0, REG_STATUS, 32'h1, rd);
        cycles(1);
        chk("irq_set_wins", {31'b0, irq}, 1);
        access(0, 4'h0, 1'b1, REG_STATUS, 0, rd); chk("status_set_wins", rd, 32'h1);
        access(0, 4'hF, 1'b0, REG_RISE_EN, 32'h0, rd);
        access(0, 4'hF, 1'b0, REG_FALL_EN, 32'h0, rd);
        access(0, 4'h0, 1'b1, REG_STATUS, 0, rd); chk("status_keeps_on_disable", rd, 32'h1);
        access(0, 4'hF, 1'b0, REG_STATUS, 32'hFFFF_FFFF, rd);
        access(0, 4'h0, 1'b1, REG_STATUS, 0, rd); chk("status_cleared", rd, 32'h0);

        // 8-pin build: upper bits read 0
        access(1, 4'hF, 1'b0, REG_DIR,  32'hFFFF_FFFF, rd);
        access(1, 4'hF, 1'b0, REG_DATA, 32'hFFFF_FFFF, rd);
        access(1, 4'h0, 1'b1, REG_OUT, 0, rd);    chk("io8_out", rd, 32'h0000_00FF);
        access(1, 4'h0, 1'b1, REG_DIR, 0, rd);    chk("io8_dir", rd, 32'h0000_00FF);
        chk("io8_pins", {24'b0, io8_pins}, 32'h0000_00FF);
        access(1, 4'h0, 1'b1, 16'h0040, 0, rd);   chk("io8_unmapped", rd, 32'h0);

        // Reset in the middle of a read
        tb_en = '0;
        access(0, 4'hF, 1'b0, REG_DIR, 32'hFFFF_FFFF, rd);
        access(0, 4'hF, 1'b0, REG_DATA, 32'h0000_5A5A, rd);
        drive(0, 4'h0, 1'b1, REG_OUT, 0);
        @(posedge clk); #1;
        chk("midread_done", {31'b0, bus.ctrl_done}, 1);
        chk("midread_rdat", bus.ctrl_rdat, 32'h0000_5A5A);
        #2 resetn = 1'b0;
        #1;
        chk("reset_clears_done", {31'b0, bus.ctrl_done}, 0);
        chk("reset_clears_rdat", bus.ctrl_rdat, 32'h0);
        drive(0, 4'h0, 1'b0, 16'h0, 32'h0);
        cycles(2);
        resetn = 1'b1;
        cycles(1);
        access(0, 4'h0, 1'b1, REG_OUT, 0, rd);    chk("post_reset_out", rd, 32'h0);
        access(0, 4'h0, 1'b1, REG_DIR, 0, rd);    chk("post_reset_dir", rd, 32'h0);
        access(1, 4'h0, 1'b1, REG_OUT, 0, rd);    chk("post_reset_io8_out", rd, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/icosoc_mod_gpio_irq.md
Name: icosoc_mod_gpio_irq

Overview:
Parametrised GPIO peripheral on the icoSoC ctrl bus. Per-pin direction and output data, plus atomic set/clear/toggle, byte-lane writes, synchronised inputs, and per-pin rising/falling edge detection. Sticky edge status drives one registered interrupt line to the CPU. Pins are driven through SB_IO tristate cells.

Parameters:
CLOCK_FREQ_HZ, 0, system clock frequency; informational, unused by logic.
IO_LENGTH, 32, number of pins, 1..32; register bits at or above IO_LENGTH read 0 and ignore writes.
SYNC_STAGES, 2, input synchroniser depth, 2..4.

Ports:
clk  in  1  system clock.
resetn  in  1  asynchronous active-low reset; clears all state immediately.
ctrl_wr  in  4  byte-lane write strobes; any bit set means write request.
ctrl_rd  in  1  read request.
ctrl_addr  in  16  byte address within the module.
ctrl_wdat  in  32  write data.
ctrl_rdat  out  32  read data, valid while ctrl_done=1.
ctrl_done  out  1  one-cycle access acknowledge.
irq  out  1  interrupt request, level, registered.
IO  inout  IO_LENGTH  package pins.

Behaviour:
- Reset values: io_out=0, io_dir=0 (all inputs), RISE_EN=0, FALL_EN=0, STATUS=0, synchroniser and previous-sample flops=0, ctrl_rdat=0, ctrl_done=0, irq=0.
- Handshake: a request is accepted when (|ctrl_wr or ctrl_rd) and ctrl_done=0. ctrl_done=1 on the next cycle for exactly one cycle. Requests held during ctrl_done=1 are ignored. The master holds a request until it sees done.
- Write and read in the same request: the write is applied, and ctrl_rdat returns the pre-write value.
- Byte lanes: ctrl_wr[k] enables ctrl_wdat[8k+7:8k] for DATA, DIR, RISE_EN, FALL_EN, SET, CLR, TGL and STATUS.
- Register map (ctrl_addr):
  0x00 DATA: write sets io_out. Read returns the synchronised input (pin value even for outputs).
  0x04 DIR: 1 = output. Read-write.
  0x08 SET: write-1 sets io_out bits. Reads 0.
  0x0C CLR: write-1 clears io_out bits. Reads 0.
  0x10 TGL: write-1 inverts io_out bits. Reads 0.
  0x14 RISE_EN, 0x18 FALL_EN: per-pin edge enables. Read-write.
  0x1C STATUS: sticky edge flags. Write-1-to-clear.
  0x20 OUT: read-only, returns io_out.
  Other addresses: writes ignored, reads 0, ctrl_done still pulses.
- Input path: SYNC_STAGES flop chain per pin; sync = last stage; prev = sync delayed one cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
  - STATUS[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Latency:
  - Pin change at edge t appears in DATA reads from t+SYNC_STAGES.
  - STATUS bit set at t+SYNC_STAGES+1.
  - irq = |STATUS, registered, so asserts at t+SYNC_STAGES+2.
  - Output writes reach D_OUT/OUTPUT_ENABLE the cycle after acceptance.
- Simultaneous events:
  - A W1C in the same cycle a new edge sets the same bit leaves the bit set (set wins).
  - Clearing an enable does not clear existing STATUS bits.
- Edges are flagged only for enabled bits; flops reset to 0, so a pin high at reset raises no flag until software enables it.
- resetn asserted mid-access: ctrl_done and ctrl_rdat clear asynchronously; the access is lost and no partial write survives.
- SB_IO: PIN_TYPE 6'b1010_01, no pullup, OUTPUT_ENABLE=io_dir, D_OUT_0=io_out, D_IN_0 feeds the synchroniser.

Decomposition:
- Package gpio_pkg: register offset constants (DATA..OUT), MAX_IO=32.
- Sub-module gpio_sync_edge, parameter SYNC_STAGES, vectorised IO_LENGTH wide: synchroniser + prev flop, outputs sync, rise, fall.
- Top holds the register file, STATUS, irq, ctrl FSM (IDLE/DONE implicit via ctrl_done) and the SB_IO array.

Test Plan:
1. Reset then read 0x04, 0x20, 0x1C -> all return 0; irq=0; ctrl_done is exactly one cycle after each request.
2. Write DIR=0xFFFF_FFFF; DATA=0x0000_00F0; SET=0x1; CLR=0x10; TGL=0x3 -> OUT reads 0x0000_00E2; IO pins match.
3. Byte-lane write: ctrl_wr=4'b0100, wdat=0xAABBCCDD to DIR (previously 0) -> DIR reads 0x00BB_0000.
4. DIR=0, RISE_EN=0x1, drive IO[0] 0->1 at cycle t -> STATUS=0x1 at t+3, irq=1 at t+4 (SYNC_STAGES=2). Write STATUS=0x1 -> irq drops 2 cycles after acceptance. IO[0] 1->0 with FALL_EN=0 -> no flag.
5. Drive an enabled edge on the same cycle STATUS W1C clears that bit -> bit remains 1, irq stays 1.
6. IO_LENGTH=8: write DATA=0xFFFF_FFFF with DIR=0xFF -> OUT reads 0x0000_00FF. Read 0x40 -> 0 with done. Assert resetn mid-read -> ctrl_done=0 immediately, all registers reset.
